// File: rtl/game_ctrl_fsm.sv
// Multi-round whack-a-mole game controller: start/load/game/end sequencing, round timer and scoring.
// Optional pause support is enabled by defining GAME_PAUSE_EN.
module game_ctrl_fsm #(
  parameter int unsigned TIME_W     = 16,
  parameter int unsigned GAME_TICKS = 3000,
  parameter int unsigned NUM_ROUNDS = 3,
  parameter int unsigned ROUND_W    = 2,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               tick,
  input  logic               load_done,
  input  logic               hit,
  input  logic               miss,
  output logic               state_start,
  output logic               state_game,
  output logic               state_game_end,
  output logic               load_req,
  output logic               load_sel,
  output logic [ROUND_W-1:0] round_idx,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses
);

  typedef enum logic [2:0] {
    START     = 3'd0,
    LOAD_GAME = 3'd1,
    GAME      = 3'd2,
    LOAD_END  = 3'd3,
    GAME_END  = 3'd4,
    PAUSE     = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 start_q;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   miss_q, miss_d;
  logic                 state_start_q, state_game_q, state_game_end_q;
  logic                 load_req_q, load_sel_q;
  logic                 start_press;
  logic                 pause_press;

  assign start_press = start_btn & ~start_q;

`ifdef GAME_PAUSE_EN
  logic pause_q;
  assign pause_press = pause_btn & ~pause_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pause_q <= 1'b1;
    else       pause_q <= pause_btn;
  end
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign pause_press  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    time_d  = time_q;
    score_d = score_q;
    miss_d  = miss_q;
    case (state_q)
      START: begin
        if (start_press) begin
          state_d = LOAD_GAME;
          round_d = '0;
          score_d = '0;
          miss_d  = '0;
        end
      end
      LOAD_GAME: begin
        if (load_done) begin
          state_d = GAME;
          time_d  = TIME_W'(GAME_TICKS);
        end
      end
      GAME: begin
        if (hit && score_q != '1) score_d = score_q + 1'b1;
        if (miss && miss_q != '1) miss_d = miss_q + 1'b1;
        // End of round wins over a pause press in the same cycle
        if (tick) time_d = time_q - 1'b1;
        if (tick && time_q == TIME_W'(1)) begin
          if (round_q < ROUND_W'(NUM_ROUNDS - 1)) begin
            state_d = LOAD_GAME;
            round_d = round_q + 1'b1;
          end else begin
            state_d = LOAD_END;
          end
        end else if (pause_press) begin
          state_d = PAUSE;
        end
      end
      LOAD_END: begin
        if (load_done) state_d = GAME_END;
      end
      GAME_END: begin
        if (start_press) state_d = START;
      end
`ifdef GAME_PAUSE_EN
      PAUSE: begin
        if (pause_press) state_d = GAME;
      end
`endif
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= START;
      start_q          <= 1'b1;
      round_q          <= '0;
      time_q           <= '0;
      score_q          <= '0;
      miss_q           <= '0;
      state_start_q    <= 1'b1;
      state_game_q     <= 1'b0;
      state_game_end_q <= 1'b0;
      load_req_q       <= 1'b0;
      load_sel_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      start_q          <= start_btn;
      round_q          <= round_d;
      time_q           <= time_d;
      score_q          <= score_d;
      miss_q           <= miss_d;
      state_start_q    <= (state_d == START);
      state_game_q     <= (state_d == GAME);
      state_game_end_q <= (state_d == GAME_END);
      load_req_q       <= (state_d == LOAD_GAME) || (state_d == LOAD_END);
      load_sel_q       <= (state_d == LOAD_END);
    end
  end

  assign state_start    = state_start_q;
  assign state_game     = state_game_q;
  assign state_game_end = state_game_end_q;
  assign load_req       = load_req_q;
  assign load_sel       = load_sel_q;
  assign round_idx      = round_q;
  assign time_left      = time_q;
  assign score          = score_q;
  assign misses         = miss_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed self-checking bench for game_ctrl_fsm (GAME_TICKS=4, NUM_ROUNDS=2);
// a second instance with SCORE_W=2 shares the stimulus to exercise saturation.
module tb_game_ctrl_fsm;

  logic clk = 1'b0;
  logic reset, start_btn, pause_btn, tick, load_done, hit, miss;

  logic       s_start, s_game, s_end, l_req, l_sel;
  logic [1:0] r_idx;
  logic [15:0] t_left;
  logic [7:0] sc, ms;

  logic       s_start2, s_game2, s_end2, l_req2, l_sel2;
  logic [1:0] r_idx2;
  logic [15:0] t_left2;
  logic [1:0] sc2, ms2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_ctrl_fsm #(.TIME_W(16), .GAME_TICKS(4), .NUM_ROUNDS(2), .ROUND_W(2), .SCORE_W(8)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn), .tick(tick),
    .load_done(load_done), .hit(hit), .miss(miss),
    .state_start(s_start), .state_game(s_game), .state_game_end(s_end),
    .load_req(l_req), .load_sel(l_sel), .round_idx(r_idx), .time_left(t_left),
    .score(sc), .misses(ms)
  );

  game_ctrl_fsm #(.TIME_W(16), .GAME_TICKS(4), .NUM_ROUNDS(2), .ROUND_W(2), .SCORE_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn), .tick(tick),
    .load_done(load_done), .hit(hit), .miss(miss),
    .state_start(s_start2), .state_game(s_game2), .state_game_end(s_end2),
    .load_req(l_req2), .load_sel(l_sel2), .round_idx(r_idx2), .time_left(t_left2),
    .score(sc2), .misses(ms2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic st, input logic gm, input logic ge,
                             input logic lr, input logic ls);
    check({tag, ".start"}, 32'(s_start), 32'(st));
    check({tag, ".game"}, 32'(s_game), 32'(gm));
    check({tag, ".end"}, 32'(s_end), 32'(ge));
    check({tag, ".load_req"}, 32'(l_req), 32'(lr));
    check({tag, ".load_sel"}, 32'(l_sel), 32'(ls));
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b1; pause_btn = 1'b0; tick = 1'b0;
    load_done = 1'b0; hit = 1'b0; miss = 1'b0;
    #22;
    check_flags("rst", 1, 0, 0, 0, 0);
    check("rst.round", 32'(r_idx), 0);
    check("rst.time", 32'(t_left), 0);
    check("rst.score", 32'(sc), 0);
    check("rst.misses", 32'(ms), 0);

    // start held across reset release is not a press
    @(posedge clk); #1; reset = 1'b0;
    step(); step();
    check_flags("held", 1, 0, 0, 0, 0);

    start_btn = 1'b0; step();
    start_btn = 1'b1; step();
    check_flags("press", 0, 0, 0, 1, 0);
    check("press.round", 32'(r_idx), 0);
    start_btn = 1'b0;

    // hit outside GAME must not count
    hit = 1'b1; step(); hit = 1'b0;
    check("ldhit.score", 32'(sc), 0);

    load_done = 1'b1; step(); load_done = 1'b0;
    check_flags("g0", 0, 1, 0, 0, 0);
    check("g0.time", 32'(t_left), 4);
    check("g0.round", 32'(r_idx), 0);

    hit = 1'b1; step(); step(); step();
    miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
    check("g0.score", 32'(sc), 4);
    check("g0.misses", 32'(ms), 1);
    check("sat.score4", 32'(sc2), 3);

    // start press and load_done in GAME are ignored
    start_btn = 1'b1; load_done = 1'b1; step(); start_btn = 1'b0; load_done = 1'b0;
    check("ign.game", 32'(s_game), 1);
    check("ign.time", 32'(t_left), 4);

    tick = 1'b1;
    step(); check("g0.t3", 32'(t_left), 3);
    step(); check("g0.t2", 32'(t_left), 2);
    step(); check("g0.t1", 32'(t_left), 1);
    hit = 1'b1; step(); tick = 1'b0; hit = 1'b0;
    check("fin.time", 32'(t_left), 0);
    check("fin.score", 32'(sc), 5);
    check("sat.score5", 32'(sc2), 3);
    check_flags("fin", 0, 0, 0, 1, 0);
    check("fin.round", 32'(r_idx), 1);

    load_done = 1'b1; step(); load_done = 1'b0;
    check_flags("g1", 0, 1, 0, 0, 0);
    check("g1.time", 32'(t_left), 4);
    tick = 1'b1; step(); tick = 1'b0;
    check("g1.t3", 32'(t_left), 3);

    pause_btn = 1'b1; step(); pause_btn = 1'b0;
`ifdef GAME_PAUSE_EN
    check("pause.game", 32'(s_game), 0);
    tick = 1'b1; hit = 1'b1; step(); hit = 1'b0; step(); tick = 1'b0;
    check("pause.time", 32'(t_left), 3);
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    check("resume.game", 32'(s_game), 1);
    check("resume.time", 32'(t_left), 3);
    check("resume.score", 32'(sc), 5);
`else
    check("nopause.game", 32'(s_game), 1);
    check("nopause.time", 32'(t_left), 3);
`endif
    step();

    tick = 1'b1; step(); step(); step(); tick = 1'b0;
    check("last.time", 32'(t_left), 0);
    check_flags("lend", 0, 0, 0, 1, 1);
    check("lend.round", 32'(r_idx), 1);

    load_done = 1'b1; step(); load_done = 1'b0;
    check_flags("gend", 0, 0, 1, 0, 0);
    check("gend.score", 32'(sc), 5);
    check("gend.misses", 32'(ms), 1);

    start_btn = 1'b1; step(); start_btn = 1'b0;
    check_flags("restart", 1, 0, 0, 0, 0);
    step();
    start_btn = 1'b1; step(); start_btn = 1'b0;
    check("new.score", 32'(sc), 0);
    check("new.misses", 32'(ms), 0);
    check("new.round", 32'(r_idx), 0);

    // reach round 1, time_left 2, score 5, then reset asynchronously
    load_done = 1'b1; step(); load_done = 1'b0;
    hit = 1'b1; repeat (5) step(); hit = 1'b0;
    tick = 1'b1; repeat (4) step(); tick = 1'b0;
    load_done = 1'b1; step(); load_done = 1'b0;
    tick = 1'b1; repeat (2) step(); tick = 1'b0;
    check("mid.round", 32'(r_idx), 1);
    check("mid.time", 32'(t_left), 2);
    check("mid.score", 32'(sc), 5);
    #2 reset = 1'b1;
    #1;
    check_flags("arst", 1, 0, 0, 0, 0);
    check("arst.round", 32'(r_idx), 0);
    check("arst.time", 32'(t_left), 0);
    check("arst.score", 32'(sc), 0);
    check("arst.misses", 32'(ms), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
